// File: rtl/pairing_input_loader_pkg.sv
// Shared constants for the pairing input loader: field/word geometry, trit codes, FSM states.
// Pure declarations; nothing here carries timing or flow-control behaviour.
package pairing_input_loader_pkg;

    localparam int M_DEF          = 97;
    localparam int W_DEF          = 32;
    localparam int NW_DEF         = (2 * M_DEF + W_DEF - 1) / W_DEF;
    localparam int RST_CYCLES_DEF = 2;
    localparam int CNT_W          = 5;

    localparam logic [1:0] TRIT0 = 2'b00;
    localparam logic [1:0] TRIT1 = 2'b01;
    localparam logic [1:0] TRIT2 = 2'b10;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CHECK = 2'd1,
        START = 2'd2,
        RUN   = 2'd3
    } state_e;

    function automatic logic trit_illegal(input logic [1:0] t);
        return !((t == TRIT0) || (t == TRIT1) || (t == TRIT2));
    endfunction

endpackage

// File: rtl/f3_word_check.sv
// Flags one input word as malformed: any 2'b11 trit or any set bit under the pad mask.
// Purely combinational, zero latency; no flow control.
module f3_word_check
    import pairing_input_loader_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] i_word,
    input  logic [W-1:0] i_pad_mask,
    output logic         o_bad
);

    logic w_trit_bad;

    always_comb begin
        w_trit_bad = 1'b0;
        for (int k = 0; k < W / 2; k++) begin
            if (trit_illegal(i_word[2*k +: 2])) begin
                w_trit_bad = 1'b1;
            end
        end
    end

    assign o_bad = w_trit_bad | (|(i_word & i_pad_mask));

endmodule

// File: rtl/pairing_input_loader.sv
// Streams x1,y1,x2,y2 into stable operands, validates them, then pulses the core's reset and waits for done.
// Full set loads in 4*NW cycles; in_ready depends on state only, so words are held off outside LOAD.
module pairing_input_loader
    import pairing_input_loader_pkg::*;
#(
    parameter int M          = M_DEF,
    parameter int W          = W_DEF,
    parameter int NW         = (2 * M + W - 1) / W,
    parameter int RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           core_done,
    output logic           core_reset,
    output logic [2*M-1:0] x1,
    output logic [2*M-1:0] y1,
    output logic [2*M-1:0] x2,
    output logic [2*M-1:0] y2,
    output logic           busy,
    output logic           pair_done,
    output logic           err
);

    localparam int             LAST_BITS = 2 * M - (NW - 1) * W;
    localparam int             WIX_W     = (NW > 1) ? $clog2(NW) : 1;
    localparam int             RC_W      = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(4 * NW - 1);

    function automatic logic [W-1:0] pad_mask_last();
        logic [W-1:0] m;
        for (int b = 0; b < W; b++) begin
            m[b] = (b >= LAST_BITS);
        end
        return m;
    endfunction

    localparam logic [W-1:0] PAD_LAST = pad_mask_last();

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [RC_W-1:0]    r_rst_cnt;
    logic               r_bad;
    logic               r_pair_done;
    logic [2*M-1:0]     r_op [4];

    logic [1:0]         w_elem;
    logic [WIX_W-1:0]   w_word;
    logic [W-1:0]       w_pad_mask;
    logic               w_word_bad;
    logic               w_xfer;
    logic               w_rst_last;

    // Counter splits into element (x1,y1,x2,y2) and word slot within it.
    assign w_elem     = 2'(r_cnt / CNT_W'(NW));
    assign w_word     = WIX_W'(r_cnt % CNT_W'(NW));
    assign w_pad_mask = (w_word == WIX_W'(NW - 1)) ? PAD_LAST : '0;
    assign w_xfer     = in_valid & in_ready;
    assign w_rst_last = (r_rst_cnt == RC_W'(RST_CYCLES - 1));

    f3_word_check #(.W(W)) u_word_check (
        .i_word     (in_data),
        .i_pad_mask (w_pad_mask),
        .o_bad      (w_word_bad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD:    if (w_xfer && (r_cnt == CNT_LAST)) w_next = CHECK;
            CHECK:   w_next = r_bad ? LOAD : START;
            START:   if (w_rst_last) w_next = RUN;
            RUN:     if (core_done) w_next = LOAD;
            default: w_next = LOAD;
        endcase
    end

    // Core stays in reset while the loader itself is in reset.
    always_comb begin
        in_ready   = (r_state == LOAD);
        core_reset = reset | (r_state == START);
        err        = (r_state == CHECK) & r_bad;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rst_cnt   <= '0;
            r_bad       <= 1'b0;
            r_pair_done <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
            end
            r_rst_cnt   <= (r_state == START) ? r_rst_cnt + RC_W'(1) : '0;
            r_pair_done <= (r_state == RUN) & core_done;
            if (w_xfer) begin
                r_bad <= r_bad | w_word_bad;
            end else if (r_state == CHECK) begin
                r_bad <= 1'b0;
            end
        end
    end

    // Bits past 2*M in the last word are padding and never stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < 4; e++) begin
                r_op[e] <= '0;
            end
        end else if (w_xfer) begin
            for (int b = 0; b < 2 * M; b++) begin
                if ((b / W) == int'(w_word)) begin
                    r_op[w_elem][b] <= in_data[b % W];
                end
            end
        end
    end

    assign x1        = r_op[0];
    assign y1        = r_op[1];
    assign x2        = r_op[2];
    assign y2        = r_op[3];
    assign busy      = (r_state != LOAD) | (r_cnt != '0);
    assign pair_done = r_pair_done;

endmodule

// File: tb/tb_pairing_input_loader.sv
// Directed bench for pairing_input_loader: load/accept, reject paths, stalls, done tracking, mid-load reset.
module tb_pairing_input_loader;

    localparam int M      = 97;
    localparam int W      = 32;
    localparam int NW     = 7;
    localparam int NWORDS = 4 * NW;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           core_done = 1'b0;
    logic           in_ready;
    logic           core_reset;
    logic [2*M-1:0] x1, y1, x2, y2;
    logic           busy, pair_done, err;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int pd_cnt = 0;
    int cr_cnt = 0;

    logic [W-1:0] vec [NWORDS];

    always #5 clk = ~clk;

    pairing_input_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .core_done  (core_done),
        .core_reset (core_reset),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .busy       (busy),
        .pair_done  (pair_done),
        .err        (err)
    );

    always @(negedge clk) begin
        if (!reset) begin
            if (err) err_cnt++;
            if (pair_done) pd_cnt++;
            if (core_reset) cr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [2*M-1:0] got, input logic [2*M-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [2*M-1:0] elem(input int e);
        logic [NW*W-1:0] t;
        for (int k = 0; k < NW; k++) t[k*W +: W] = vec[e*NW + k];
        return t[2*M-1:0];
    endfunction

    task automatic clear_vec();
        for (int i = 0; i < NWORDS; i++) vec[i] = '0;
    endtask

    // Called at a negedge; returns at the negedge after the n-th transfer.
    task automatic load_words(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            @(posedge clk);
            @(negedge clk);
            check("busy_load", busy, 1);
            if (gap && i < NWORDS - 1) begin
                in_valid = 1'b0;
                in_data  = 32'hFFFF_FFFF;
                @(negedge clk);
                check("busy_gap", busy, 1);
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic expect_start();
        check("chk_err", err, 0);
        check("chk_core_reset", core_reset, 0);
        check("chk_in_ready", in_ready, 0);
        @(negedge clk);
        check("start1_core_reset", core_reset, 1);
        core_done = 1'b0;
        @(negedge clk);
        check("start2_core_reset", core_reset, 1);
        @(negedge clk);
        check("run_core_reset", core_reset, 0);
        check("run_in_ready", in_ready, 0);
        check("run_busy", busy, 1);
    endtask

    task automatic expect_reject();
        check("rej_err", err, 1);
        check("rej_core_reset", core_reset, 0);
        check("rej_in_ready", in_ready, 0);
        @(negedge clk);
        check("rej_err_clear", err, 0);
        check("rej_in_ready_back", in_ready, 1);
        check("rej_busy", busy, 0);
        check("rej_core_reset_low", core_reset, 0);
    endtask

    task automatic finish_run();
        int p0;
        #1;
        p0 = pd_cnt;
        core_done = 1'b1;
        @(negedge clk);
        check("pd_pulse", pair_done, 1);
        check("pd_in_ready", in_ready, 1);
        check("pd_busy", busy, 0);
        @(negedge clk);
        check("pd_clear", pair_done, 0);
        @(negedge clk);
        check("pd_done_ignored", pair_done, 0);
        #1;
        check("pd_count", pd_cnt - p0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int e0;
        int c0;
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_core_reset", core_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_pair_done", pair_done, 0);
        check("rst_err", err, 0);
        check("rst_x1", x1, 0);
        check("rst_y2", y2, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_core_reset", core_reset, 0);
        check("idle_busy", busy, 0);

        // Valid set, x1 = 1
        clear_vec();
        vec[0] = 32'h1;
        load_words(NWORDS, 1'b0);
        expect_start();
        check("t1_x1", x1, 194'h1);
        check("t1_y1", y1, 194'h0);
        repeat (3) begin
            @(negedge clk);
            check("t1_run_wait", pair_done, 0);
        end
        #1;
        check("t1_err_cnt", err_cnt, 0);
        check("t1_cr_cnt", cr_cnt, 2);
        finish_run();

        // Illegal trit in y2 word 3; core_done still high and must be ignored
        clear_vec();
        vec[3*NW + 3] = 32'hC;
        load_words(NWORDS, 1'b0);
        expect_reject();
        check("t2_y2_kept", y2, 194'hC_000000000000000000000000);
        #1;
        check("t2_err_cnt", err_cnt, 1);
        check("t2_cr_cnt", cr_cnt, 2);
        check("t2_pd_cnt", pd_cnt, 1);

        // Padding bit set in x2 last word
        clear_vec();
        vec[2*NW + 6] = 32'h8000_0000;
        @(negedge clk);
        load_words(NWORDS, 1'b0);
        expect_reject();
        #1;
        check("t3_err_cnt", err_cnt, 2);
        check("t3_cr_cnt", cr_cnt, 2);

        // Stalled load with mixed legal patterns, then long core run
        for (int i = 0; i < NWORDS; i++) begin
            case (i / NW)
                0: vec[i] = 32'h5555_5555;
                1: vec[i] = 32'hAAAA_AAAA;
                2: vec[i] = 32'h9999_9999;
                default: vec[i] = 32'h6666_6666;
            endcase
            if (i % NW == NW - 1) vec[i] = (i / NW == 1) ? 32'h2 : 32'h1;
        end
        @(negedge clk);
        load_words(NWORDS, 1'b1);
        expect_start();
        check("t4_x1", x1, elem(0));
        check("t4_y1", y1, elem(1));
        check("t4_x2", x2, elem(2));
        check("t4_y2", y2, elem(3));
        check("t4_x1_top", x1[193:192], 2'b01);
        check("t4_y1_top", y1[193:192], 2'b10);
        #1;
        c0 = pd_cnt;
        e0 = err_cnt;
        repeat (100) begin
            @(negedge clk);
            check("t5_in_ready_low", in_ready, 0);
        end
        #1;
        check("t5_no_pd", pd_cnt - c0, 0);
        check("t4_no_err", err_cnt - e0, 0);
        finish_run();

        // Reset in the middle of a load
        clear_vec();
        for (int i = 0; i < NWORDS; i++) vec[i] = 32'h1111_1111;
        @(negedge clk);
        load_words(15, 1'b0);
        reset = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_core_reset", core_reset, 1);
        check("t6_in_ready", in_ready, 1);
        check("t6_x1", x1, 0);
        check("t6_y1", y1, 0);
        core_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        clear_vec();
        vec[0]        = 32'h2;
        vec[NW]       = 32'h1;
        vec[2*NW + 6] = 32'h2;
        vec[3*NW + 5] = 32'h9;
        @(negedge clk);
        load_words(NWORDS, 1'b0);
        expect_start();
        check("t6_new_x1", x1, 194'h2);
        check("t6_new_y1", y1, 194'h1);
        check("t6_new_x2", x2, 194'h2_000000000000000000000000000000000000000000000000);
        check("t6_new_y2", y2, 194'h9_0000000000000000000000000000000000000000);
        finish_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
